// File: rtl/pwr_ctrl_pkg.sv
// Shared encodings for the range-hood power/gesture controller.
package pwr_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ON      = 2'd1,
    HOLD    = 2'd2,
    LOCKOUT = 2'd3
  } main_state_t;

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_LEFT  = 2'd1,
    G_RIGHT = 2'd2
  } gest_state_t;

  localparam int unsigned EV_ON  = 0;
  localparam int unsigned EV_OFF = 1;

endpackage

// File: rtl/power_gesture_ctrl_if.sv
// Button inputs and power/gesture status of power_gesture_ctrl.
interface power_gesture_ctrl_if;
  logic       on_off_btn;
  logic       left_btn;
  logic       right_btn;
  logic       gesture_en;
  logic       power_on;
  logic       gesture_armed;
  logic       gesture_dir;
  logic [1:0] ev_pulse;

  modport master (
    output on_off_btn, left_btn, right_btn, gesture_en,
    input  power_on, gesture_armed, gesture_dir, ev_pulse
  );

  modport slave (
    input  on_off_btn, left_btn, right_btn, gesture_en,
    output power_on, gesture_armed, gesture_dir, ev_pulse
  );
endinterface

// File: rtl/btn_debounce.sv
// 2-flop synchroniser plus stability-count debouncer; rise pulses with the new high level.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // sync2 has differed from level for DEB_CYCLES consecutive cycles
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/power_gesture_ctrl.sv
// Range-hood power on/off controller: short press on, long hold off, optional swipe gestures.
// Gesture path is compiled in only when PWR_CTRL_GESTURE_EN is defined.
module power_gesture_ctrl
  import pwr_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEB_CYCLES     = 1_000_000,
  parameter int unsigned HOLD_CYCLES    = 300_000_000,
  parameter int unsigned GESTURE_CYCLES = 500_000_000
) (
  input logic                 clk,
  input logic                 reset,
  power_gesture_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] G_LAST    = CNT_W'(GESTURE_CYCLES - 1);

  logic on_level;
  logic on_rise;
  logic g_on_req;
  logic g_off_req;

  main_state_t      state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]       ev_q, ev_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_on (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.on_off_btn),
    .level (on_level),
    .rise  (on_rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= OFF;
      hold_cnt_q <= '0;
      ev_q       <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      ev_q       <= ev_d;
    end
  end

  // on_off edge is checked before gesture requests, so it wins a collision
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    ev_d       = '0;
    case (state_q)
      OFF: begin
        if (on_rise || g_on_req) begin
          state_d      = ON;
          ev_d[EV_ON]  = 1'b1;
        end
      end
      ON: begin
        if (on_rise) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end else if (g_off_req) begin
          state_d      = OFF;
          ev_d[EV_OFF] = 1'b1;
        end
      end
      HOLD: begin
        if (!on_level) begin
          state_d    = ON;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d      = LOCKOUT;
          ev_d[EV_OFF] = 1'b1;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (!on_level) state_d = OFF;
      end
      default: state_d = OFF;
    endcase
  end

  always_comb begin
    bus.power_on = (state_q == ON) || (state_q == HOLD);
    bus.ev_pulse = ev_q;
  end

`ifdef PWR_CTRL_GESTURE_EN
  logic             left_rise;
  logic             right_rise;
  logic             left_level_unused;
  logic             right_level_unused;
  logic             g_active;
  gest_state_t      gstate_q, gstate_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.left_btn),
    .level (left_level_unused),
    .rise  (left_rise)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.right_btn),
    .level (right_level_unused),
    .rise  (right_rise)
  );

  assign g_active  = bus.gesture_en && ((state_q == OFF) || (state_q == ON));
  assign g_on_req  = g_active && (gstate_q == G_LEFT)  && right_rise;
  assign g_off_req = g_active && (gstate_q == G_RIGHT) && left_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gstate_q <= G_IDLE;
      gcnt_q   <= '0;
    end else begin
      gstate_q <= gstate_d;
      gcnt_q   <= gcnt_d;
    end
  end

  // Abort looks at the main FSM's next state so a press entering HOLD disarms at once
  always_comb begin
    gstate_d = gstate_q;
    gcnt_d   = gcnt_q;
    if (!g_active || (state_d == HOLD) || (state_d == LOCKOUT)) begin
      gstate_d = G_IDLE;
    end else begin
      case (gstate_q)
        G_IDLE: begin
          if (left_rise && !right_rise) begin
            gstate_d = G_LEFT;
            gcnt_d   = '0;
          end else if (right_rise && !left_rise) begin
            gstate_d = G_RIGHT;
            gcnt_d   = '0;
          end
        end
        G_LEFT: begin
          if (right_rise)             gstate_d = G_IDLE;
          else if (left_rise)         gcnt_d   = '0;
          else if (gcnt_q == G_LAST)  gstate_d = G_IDLE;
          else if (gcnt_q != '1)      gcnt_d   = gcnt_q + 1'b1;
        end
        G_RIGHT: begin
          if (left_rise)              gstate_d = G_IDLE;
          else if (right_rise)        gcnt_d   = '0;
          else if (gcnt_q == G_LAST)  gstate_d = G_IDLE;
          else if (gcnt_q != '1)      gcnt_d   = gcnt_q + 1'b1;
        end
        default: gstate_d = G_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.gesture_armed = (gstate_q != G_IDLE);
    bus.gesture_dir   = (gstate_q == G_RIGHT);
  end
`else
  logic             unused_gesture_in;
  logic [CNT_W-1:0] unused_g_last;

  assign unused_gesture_in = ^{bus.left_btn, bus.right_btn, bus.gesture_en};
  assign unused_g_last     = G_LAST;
  assign g_on_req          = 1'b0;
  assign g_off_req         = 1'b0;

  always_comb begin
    bus.gesture_armed = 1'b0;
    bus.gesture_dir   = 1'b0;
  end
`endif

endmodule
